// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and helpers for the stage sequencer
//
// Contents:
//   seq_state_t : sequencer state encoding
//   wait_cnt_w  : width of the memory wait counter for a given timeout

package seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      ERR    = 3'd6
   } seq_state_t;

   // The counter only has to reach timeout-1, so clog2(timeout) bits suffice.
   // Guarded so a degenerate timeout still yields a legal one-bit counter.
   function automatic int wait_cnt_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - wait-cycle counter for outstanding memory requests
//
// Ports:
//   i_clk       : core clock
//   i_reset_n   : asynchronous reset, active low
//   i_clear     : restart the count from zero (state entry)
//   i_count_en  : one more cycle spent waiting for ready
//   o_expired   : count has reached MEM_TIMEOUT-1

module seq_wait_timer
   import seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);

   localparam int             W    = wait_cnt_w(MEM_TIMEOUT);
   localparam logic [W-1:0]   LAST = W'(MEM_TIMEOUT - 1);
   localparam logic [W-1:0]   ONE  = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins over counting; the count saturates at LAST so it can never
   // wrap back to zero if a caller keeps counting after expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_count_en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle one-hot stage enable sequencer
//
// Ports:
//   i_clk, i_reset_n         : clock, asynchronous active-low reset
//   i_run, i_halt            : run/halt level controls, sampled in IDLE and WB
//   i_imem_ready             : instruction word valid (used in FETCH only)
//   i_dmem_ready             : data access complete (used in MEM only)
//   i_memAccess              : instruction is a load/store (used in EXEC only)
//   o_en_if .. o_en_wb       : one-hot stage enables
//   o_imem_req, o_dmem_req   : memory requests, held until ready
//   o_busy                   : any state other than IDLE or ERR
//   o_error                  : memory timeout, held until reset
//   o_instret                : retired-instruction count

module stage_sequencer
   import seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_run,
   input  logic             i_halt,
   input  logic             i_imem_ready,
   input  logic             i_dmem_ready,
   input  logic             i_memAccess,
   output logic             o_en_if,
   output logic             o_en_id,
   output logic             o_en_ex,
   output logic             o_en_mem,
   output logic             o_en_wb,
   output logic             o_imem_req,
   output logic             o_dmem_req,
   output logic             o_busy,
   output logic             o_error,
   output logic [CNT_W-1:0] o_instret
);

   localparam logic [CNT_W-1:0] INSTRET_ONE = CNT_W'(1);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [CNT_W-1:0] instret_q;
   logic [CNT_W-1:0] instret_d;

   logic             wait_clear;
   logic             wait_count_en;
   logic             wait_expired;

   // ------------------------------------------------------------------
   // Wait counter: restarts on every state change, so each FETCH or MEM
   // visit gets a full MEM_TIMEOUT-cycle budget of its own.
   // ------------------------------------------------------------------
   assign wait_clear = (state_d != state_q);

   seq_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clear    (wait_clear),
      .i_count_en (wait_count_en),
      .o_expired  (wait_expired)
   );

   // ------------------------------------------------------------------
   // Next state and outputs. Everything except o_en_if / o_en_mem is a
   // pure decode of state_q; those two follow ready combinationally so
   // the stage latches the word in the same cycle it becomes valid.
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      wait_count_en = 1'b0;
      o_en_if       = 1'b0;
      o_en_id       = 1'b0;
      o_en_ex       = 1'b0;
      o_en_mem      = 1'b0;
      o_en_wb       = 1'b0;
      o_imem_req    = 1'b0;
      o_dmem_req    = 1'b0;
      o_error       = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_run && !i_halt) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            o_imem_req = 1'b1;
            o_en_if    = i_imem_ready;
            if (i_imem_ready) begin
               // Ready on the final permitted cycle still counts as success.
               state_d = DECODE;
            end else begin
               wait_count_en = 1'b1;
               if (wait_expired) begin
                  state_d = ERR;
               end
            end
         end

         DECODE: begin
            o_en_id = 1'b1;
            state_d = EXEC;
         end

         EXEC: begin
            o_en_ex = 1'b1;
            state_d = i_memAccess ? MEM : WB;
         end

         MEM: begin
            o_dmem_req = 1'b1;
            o_en_mem   = i_dmem_ready;
            if (i_dmem_ready) begin
               state_d = WB;
            end else begin
               wait_count_en = 1'b1;
               if (wait_expired) begin
                  state_d = ERR;
               end
            end
         end

         WB: begin
            o_en_wb = 1'b1;
            // Instruction boundary: the only place, besides IDLE, where
            // run/halt are allowed to change the flow.
            state_d = (i_halt || !i_run) ? IDLE : FETCH;
         end

         ERR: begin
            // Terminal until reset.
            o_error = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_busy = (state_q != IDLE) && (state_q != ERR);

   // ------------------------------------------------------------------
   // Retired-instruction counter: one increment per WB cycle, wraps.
   // ------------------------------------------------------------------
   always_comb begin
      instret_d = instret_q;
      if (state_q == WB) begin
         instret_d = instret_q + INSTRET_ONE;
      end
   end

   assign o_instret = instret_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard testbench for stage_sequencer

module tb_stage_sequencer;

   localparam int TO = 16;
   localparam int CW = 4;

   logic          i_clk = 1'b0;
   logic          i_reset_n;
   logic          i_run;
   logic          i_halt;
   logic          i_imem_ready;
   logic          i_dmem_ready;
   logic          i_memAccess;
   logic          o_en_if;
   logic          o_en_id;
   logic          o_en_ex;
   logic          o_en_mem;
   logic          o_en_wb;
   logic          o_imem_req;
   logic          o_dmem_req;
   logic          o_busy;
   logic          o_error;
   logic [CW-1:0] o_instret;

   stage_sequencer #(
      .MEM_TIMEOUT (TO),
      .CNT_W       (CW)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_run        (i_run),
      .i_halt       (i_halt),
      .i_imem_ready (i_imem_ready),
      .i_dmem_ready (i_dmem_ready),
      .i_memAccess  (i_memAccess),
      .o_en_if      (o_en_if),
      .o_en_id      (o_en_id),
      .o_en_ex      (o_en_ex),
      .o_en_mem     (o_en_mem),
      .o_en_wb      (o_en_wb),
      .o_imem_req   (o_imem_req),
      .o_dmem_req   (o_dmem_req),
      .o_busy       (o_busy),
      .o_error      (o_error),
      .o_instret    (o_instret)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int            lat;
      logic [4:0]    mask;
      int            dreq;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            n_vec = 0;
   int            n_bad = 0;
   logic [CW-1:0] model_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor: per-instruction observation ----------------
   logic [4:0] en;
   assign en = {o_en_wb, o_en_mem, o_en_ex, o_en_id, o_en_if};

   bit         in_instr = 1'b0;
   int         cyc, dreq, npulse;
   logic [4:0] seen;

   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         in_instr = 1'b0;
      end else begin
         if (!in_instr && o_imem_req) begin
            in_instr = 1'b1;
            cyc      = 0;
            dreq     = 0;
            npulse   = 0;
            seen     = '0;
         end
         if (en != '0) chk("onehot", 32'($countones(en) <= 1), 1);
         if (in_instr) begin
            cyc++;
            seen   = seen | en;
            dreq   = dreq + int'(o_dmem_req);
            npulse = npulse + $countones(en);
            if (o_en_wb) begin
               if (sb.size() == 0) begin
                  chk("sb_empty_at_wb", 1, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("latency",  cyc,       mon_e.lat);
                  chk("en_mask",  seen,      mon_e.mask);
                  chk("pulses",   npulse,    $countones(mon_e.mask));
                  chk("dreq_len", dreq,      mon_e.dreq);
                  chk("instret_at_wb", o_instret, mon_e.cnt);
               end
               in_instr = 1'b0;
            end
         end
      end
   end

   // ---------------- driver: one instruction with given latencies ----------------
   task automatic do_instr(input bit mem, input int ilat, input int dlat, input bit halt_dec);
      int   n = 0;
      exp_t e;
      e.lat  = 4 + ilat + (mem ? 1 + dlat : 0);
      e.mask = mem ? 5'b11111 : 5'b10111;
      e.dreq = mem ? dlat + 1 : 0;
      e.cnt  = model_cnt;
      sb.push_back(e);
      model_cnt = model_cnt + 1'b1;

      while (!o_imem_req && n < 50) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (!o_imem_req) begin
         chk("fetch_start", 0, 1);
         sb.delete();
         return;
      end
      i_imem_ready = 1'b0;
      repeat (ilat) begin @(posedge i_clk); #1; end
      i_imem_ready = 1'b1;
      @(posedge i_clk); #1;                 // DECODE
      i_dmem_ready = 1'b1;                  // ignored outside MEM
      i_memAccess  = mem;
      if (halt_dec) i_halt = 1'b1;
      @(posedge i_clk); #1;                 // EXEC
      @(posedge i_clk); #1;                 // MEM or WB
      i_memAccess  = 1'b0;
      i_imem_ready = 1'b0;
      i_dmem_ready = 1'b0;
      if (mem) begin
         repeat (dlat) begin @(posedge i_clk); #1; end
         i_dmem_ready = 1'b1;
         @(posedge i_clk); #1;              // WB
         i_dmem_ready = 1'b0;
      end
      @(posedge i_clk); #1;                 // after WB
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nf;
      i_reset_n    = 1'b0;
      i_run        = 1'b0;
      i_halt       = 1'b0;
      i_imem_ready = 1'b0;
      i_dmem_ready = 1'b0;
      i_memAccess  = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_en",   en, 0);
      chk("rst_req",  {o_imem_req, o_dmem_req}, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_err",  o_error, 0);
      chk("rst_cnt",  o_instret, 0);
      i_reset_n = 1'b1;
      repeat (3) begin @(posedge i_clk); #1; end
      chk("idle_hold", o_busy, 0);

      // back-to-back non-memory instructions
      i_run = 1'b1;
      for (int i = 0; i < 10; i++) do_instr(1'b0, 0, 0, 1'b0);
      chk("instret10", o_instret, 10);

      // load with data ready 3 cycles after MEM entry
      do_instr(1'b1, 0, 3, 1'b0);

      for (int i = 0; i < 5; i++)
         do_instr(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      chk("instret_wrap", o_instret, 0);

      // ready on the last permitted wait cycle
      do_instr(1'b0, TO - 1, 0, 1'b0);
      do_instr(1'b1, 0, TO - 1, 1'b0);
      chk("no_err_boundary", o_error, 0);

      // halt raised in DECODE: instruction completes, then IDLE
      do_instr(1'b0, 1, 0, 1'b1);
      chk("halt_idle",    o_busy, 0);
      chk("halt_instret", o_instret, model_cnt);
      repeat (3) begin @(posedge i_clk); #1; end
      chk("halt_hold", o_busy, 0);
      i_halt = 1'b0;
      do_instr(1'b0, 0, 0, 1'b0);

      // reset while in MEM: abandoned, asynchronous clear
      nf = 0;
      while (!o_imem_req && nf < 20) begin @(posedge i_clk); #1; nf++; end
      i_imem_ready = 1'b1;
      @(posedge i_clk); #1;                 // DECODE
      i_imem_ready = 1'b0;
      i_memAccess  = 1'b1;
      @(posedge i_clk); #1;                 // EXEC
      @(posedge i_clk); #1;                 // MEM 1
      i_memAccess = 1'b0;
      @(posedge i_clk); #1;                 // MEM 2
      chk("abort_dreq_before", o_dmem_req, 1);
      #2 i_reset_n = 1'b0;
      i_run = 1'b0;
      #1;
      chk("abort_dreq", o_dmem_req, 0);
      chk("abort_en",   en, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_cnt",  o_instret, 0);
      sb.delete();
      model_cnt = '0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      repeat (3) begin @(posedge i_clk); #1; chk("abort_no_wb", o_en_wb, 0); end

      // instruction memory never ready: timeout into ERR
      i_imem_ready = 1'b0;
      i_run        = 1'b1;
      nf           = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk); #1;
         if (o_error) break;
         if (o_imem_req) nf++;
      end
      chk("timeout_cycles", nf, TO);
      chk("err_flag", o_error, 1);
      chk("err_busy", o_busy, 0);
      chk("err_req",  o_imem_req, 0);
      i_run = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      i_run = 1'b1;
      repeat (3) begin @(posedge i_clk); #1; end
      chk("err_sticky", o_error, 1);
      i_reset_n = 1'b0;
      #1;
      chk("err_cleared", o_error, 0);
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
